// File: rtl/pe_result_to_blockfp_pkg.sv
// Shared configuration, FSM encoding and field-extract helper for the
// result-to-block-floating-point converter.
package pe_result_to_blockfp_pkg;

    typedef struct packed {
        int unsigned RESULT_WIDTH;
        int unsigned RESULT_EXPONENT_WIDTH;
        int unsigned RESULT_MANTISSA_WIDTH;
        int unsigned RESULT_EXPONENT_BIAS;
        int unsigned EXPONENT_WIDTH;
        int unsigned MANTISSA_WIDTH;
        int unsigned EXPONENT_BIAS;
    } pe_cfg_t;

    localparam pe_cfg_t PE_CFG_DEFAULT = '{
        RESULT_WIDTH:          16,
        RESULT_EXPONENT_WIDTH: 5,
        RESULT_MANTISSA_WIDTH: 10,
        RESULT_EXPONENT_BIAS:  15,
        EXPONENT_WIDTH:        5,
        MANTISSA_WIDTH:        8,
        EXPONENT_BIAS:         15
    };

    // Signed width of the per-element alignment shift amount.
    localparam int unsigned BFP_ALIGN_SHIFT_WIDTH = 16;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ALIGN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Extract an unsigned field of 'width' bits starting at 'lsb'.
    function automatic logic [31:0] fp_field(input logic [63:0] v,
                                             input int unsigned lsb,
                                             input int unsigned width);
        return 32'((v >> lsb) & ((64'd1 << width) - 64'd1));
    endfunction

endpackage

// File: rtl/pe_result_to_blockfp_align.sv
// Combinational per-element unpack, alignment shift, saturation and negation
// of one floating-point result against the block's shared exponent.
module pe_result_to_blockfp_align
    import pe_result_to_blockfp_pkg::*;
#(
    parameter pe_cfg_t cfg = PE_CFG_DEFAULT
) (
    input  logic [cfg.RESULT_WIDTH-1:0]             result,
    input  logic [cfg.RESULT_EXPONENT_WIDTH-1:0]    max_e,
    input  logic signed [BFP_ALIGN_SHIFT_WIDTH-1:0] extra_shift,
    input  logic                                    saturate,
    output logic [cfg.MANTISSA_WIDTH-1:0]           mantissa_c
);
    localparam int unsigned REW        = cfg.RESULT_EXPONENT_WIDTH;
    localparam int unsigned RMW        = cfg.RESULT_MANTISSA_WIDTH;
    localparam int unsigned RW         = RMW + 1;
    localparam int unsigned MW         = cfg.MANTISSA_WIDTH;
    localparam int unsigned MAGW       = MW - 1;
    localparam int unsigned SW         = BFP_ALIGN_SHIFT_WIDTH;
    localparam int unsigned WW         = RW + MW;
    localparam int          BASE_SHIFT = int'(RW) - int'(MAGW);

    logic                 sign;
    logic [REW-1:0]       e;
    logic [RMW-1:0]       m;
    logic [RW-1:0]        sig;
    logic signed [SW-1:0] r;
    logic signed [SW-1:0] l;
    logic [WW-1:0]        shifted;
    logic [MAGW-1:0]      mag;

    assign sign = fp_field(64'(result), REW + RMW, 32'd1) != 32'd0;
    assign e    = REW'(fp_field(64'(result), RMW, REW));
    assign m    = RMW'(fp_field(64'(result), 32'd0, RMW));

    // Zero exponent (zero or denormal) contributes an exact zero.
    always_comb begin
        sig     = (e == '0) ? '0 : {1'b1, m};
        r       = $signed(SW'(max_e)) - $signed(SW'(e)) + $signed(SW'(BASE_SHIFT)) + extra_shift;
        l       = -r;
        shifted = '0;
        if (!r[SW-1]) begin
            if (r < $signed(SW'(RW))) shifted = WW'(sig) >> $unsigned(r);
        end else begin
            if (l < $signed(SW'(WW))) shifted = WW'(sig) << $unsigned(l);
        end
        mag = MAGW'(shifted);
        if (saturate && (mag != '0)) mag = '1;
        mantissa_c = sign ? -{1'b0, mag} : {1'b0, mag};
    end

endmodule

// File: rtl/pe_result_to_blockfp.sv
// Collects BLOCK_SIZE floating-point results, aligns them to their largest
// exponent and emits one block-floating-point block over valid/ready.
module pe_result_to_blockfp
    import pe_result_to_blockfp_pkg::*;
#(
    parameter pe_cfg_t     cfg        = PE_CFG_DEFAULT,
    parameter int unsigned BLOCK_SIZE = 8
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          i_valid,
    output logic                                          o_ready,
    input  logic [cfg.RESULT_WIDTH-1:0]                   i_result,
    output logic                                          o_valid,
    input  logic                                          i_ready,
    output logic [cfg.EXPONENT_WIDTH-1:0]                 o_exponent,
    output logic [BLOCK_SIZE-1:0][cfg.MANTISSA_WIDTH-1:0] o_mantissa
);
    localparam int unsigned REW      = cfg.RESULT_EXPONENT_WIDTH;
    localparam int unsigned RMW      = cfg.RESULT_MANTISSA_WIDTH;
    localparam int unsigned EW       = cfg.EXPONENT_WIDTH;
    localparam int unsigned MW       = cfg.MANTISSA_WIDTH;
    localparam int unsigned SW       = BFP_ALIGN_SHIFT_WIDTH;
    localparam int unsigned XW       = EW + 3;
    localparam int unsigned CW       = $clog2(BLOCK_SIZE);
    localparam int unsigned EXP_MAX  = (1 << EW) - 1;
    localparam int          X_OFFSET = int'(cfg.EXPONENT_BIAS) - int'(cfg.RESULT_EXPONENT_BIAS)
                                     - (int'(MW) - 2);

    state_t                          state, state_next;
    logic [CW-1:0]                   count;
    logic [REW-1:0]                  max_e;
    logic [REW-1:0]                  e_in;
    logic [cfg.RESULT_WIDTH-1:0]     buffer [BLOCK_SIZE];
    logic                            take_c, align_c, release_c, last_c;
    logic signed [XW-1:0]            x_raw;
    logic signed [SW-1:0]            extra_shift;
    logic                            saturate;
    logic [EW-1:0]                   exponent_c;
    logic [BLOCK_SIZE-1:0][MW-1:0]   aligned_c;

    assign e_in   = REW'(fp_field(64'(i_result), RMW, REW));
    assign last_c = (count == CW'(BLOCK_SIZE - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= FILL;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (i_valid && last_c) state_next = ALIGN;
            ALIGN:   state_next = HOLD;
            HOLD:    if (i_ready) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        o_ready   = 1'b0;
        take_c    = 1'b0;
        align_c   = 1'b0;
        release_c = 1'b0;
        case (state)
            FILL:    begin o_ready = 1'b1; take_c = i_valid; end
            ALIGN:   align_c = 1'b1;
            HOLD:    release_c = i_ready;
            default: ;
        endcase
    end

    // Shared exponent; an underflowing exponent is folded into extra right shift.
    always_comb begin
        x_raw       = $signed(XW'(max_e)) + $signed(XW'(X_OFFSET));
        extra_shift = x_raw[XW-1] ? SW'(-x_raw) : '0;
        saturate    = 1'b0;
        exponent_c  = EW'(x_raw);
        if (max_e == '0 || x_raw[XW-1]) begin
            exponent_c = '0;
        end else if ($unsigned(x_raw) > XW'(EXP_MAX)) begin
            exponent_c = EW'(EXP_MAX);
            saturate   = 1'b1;
        end
    end

    for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_align
        pe_result_to_blockfp_align #(.cfg(cfg)) u_align (
            .result      (buffer[g]),
            .max_e       (max_e),
            .extra_shift (extra_shift),
            .saturate    (saturate),
            .mantissa_c  (aligned_c[g])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count      <= '0;
            max_e      <= '0;
            o_valid    <= 1'b0;
            o_exponent <= '0;
            o_mantissa <= '0;
            for (int i = 0; i < int'(BLOCK_SIZE); i++) buffer[i] <= '0;
        end else begin
            if (take_c) begin
                buffer[count] <= i_result;
                count         <= last_c ? '0 : count + CW'(1);
                if (e_in > max_e) max_e <= e_in;
            end
            if (align_c) begin
                o_exponent <= exponent_c;
                o_mantissa <= aligned_c;
                o_valid    <= 1'b1;
            end
            if (release_c) begin
                o_valid <= 1'b0;
                max_e   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pe_result_to_blockfp.sv
// Directed bench: three converters (bias 15, 0 and 30) share one input stream.
module tb_pe_result_to_blockfp;
    import pe_result_to_blockfp_pkg::*;

    localparam pe_cfg_t CFG_B0 = '{
        RESULT_WIDTH: 16, RESULT_EXPONENT_WIDTH: 5, RESULT_MANTISSA_WIDTH: 10,
        RESULT_EXPONENT_BIAS: 15, EXPONENT_WIDTH: 5, MANTISSA_WIDTH: 8, EXPONENT_BIAS: 0
    };
    localparam pe_cfg_t CFG_B30 = '{
        RESULT_WIDTH: 16, RESULT_EXPONENT_WIDTH: 5, RESULT_MANTISSA_WIDTH: 10,
        RESULT_EXPONENT_BIAS: 15, EXPONENT_WIDTH: 5, MANTISSA_WIDTH: 8, EXPONENT_BIAS: 30
    };

    logic            clock = 1'b0;
    logic            reset;
    logic            i_valid;
    logic            i_ready;
    logic [15:0]     i_result;
    logic            rdy_a, rdy_b, rdy_c;
    logic            vld_a, vld_b, vld_c;
    logic [4:0]      exp_a, exp_b, exp_c;
    logic [7:0][7:0] man_a, man_b, man_c;

    int          total = 0;
    int          bad   = 0;
    int          exp_m [8];
    logic [15:0] vec   [8];

    always #5 clock = ~clock;

    pe_result_to_blockfp #(.cfg(PE_CFG_DEFAULT), .BLOCK_SIZE(8)) dut (
        .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(rdy_a), .i_result(i_result),
        .o_valid(vld_a), .i_ready(i_ready), .o_exponent(exp_a), .o_mantissa(man_a)
    );
    pe_result_to_blockfp #(.cfg(CFG_B0), .BLOCK_SIZE(8)) dut_b0 (
        .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(rdy_b), .i_result(i_result),
        .o_valid(vld_b), .i_ready(i_ready), .o_exponent(exp_b), .o_mantissa(man_b)
    );
    pe_result_to_blockfp #(.cfg(CFG_B30), .BLOCK_SIZE(8)) dut_b30 (
        .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(rdy_c), .i_result(i_result),
        .o_valid(vld_c), .i_ready(i_ready), .o_exponent(exp_c), .o_mantissa(man_c)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [4:0] oe, input logic [7:0][7:0] om,
                           input int ee);
        chk({tag, " exp"}, 32'(oe), ee);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s m%0d", tag, i), 32'($signed(om[i])), exp_m[i]);
    endtask

    task automatic push_one(input string tag, input logic [15:0] v);
        chk({tag, " o_ready"}, 32'(rdy_a), 1);
        i_valid  = 1'b1;
        i_result = v;
        @(posedge clock); #1;
        i_valid  = 1'b0;
    endtask

    // Feeds vec[0..7] and checks o_valid rises exactly two cycles after the last transfer.
    task automatic push_block(input string tag);
        for (int i = 0; i < 8; i++) push_one(tag, vec[i]);
        chk({tag, " valid t+1"}, 32'(vld_a), 0);
        @(posedge clock); #1;
        chk({tag, " valid t+2"}, 32'(vld_a), 1);
    endtask

    task automatic release_block(input string tag);
        i_ready = 1'b1;
        @(posedge clock); #1;
        i_ready = 1'b0;
        chk({tag, " valid drop"}, 32'(vld_a), 0);
        chk({tag, " ready back"}, 32'(rdy_a), 1);
    endtask

    initial begin
        reset    = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_result = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        chk("rst o_valid", 32'(vld_a), 0);
        chk("rst o_ready", 32'(rdy_a), 1);
        chk("rst o_exponent", 32'(exp_a), 0);
        chk("rst o_mantissa", (man_a == '0) ? 32'd1 : 32'd0, 1);

        // 1.0, 0.5, -1.0 and zeros
        vec   = '{16'h3C00, 16'h3800, 16'hBC00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        push_block("t1");
        exp_m = '{64, 32, -64, 0, 0, 0, 0, 0};
        chk_blk("t1", exp_a, man_a, 9);
        chk_blk("t1 b30", exp_c, man_c, 24);
        exp_m = '{1, 0, -1, 0, 0, 0, 0, 0};
        chk_blk("t1 b0 underflow", exp_b, man_b, 0);
        release_block("t1");

        // small elements truncate to zero
        vec   = '{16'h3C00, 16'h1400, 16'h1400, 16'h1400, 16'h1400, 16'h1400, 16'h1400, 16'h1400};
        push_block("t2");
        exp_m = '{64, 0, 0, 0, 0, 0, 0, 0};
        chk_blk("t2", exp_a, man_a, 9);
        release_block("t2");

        // large magnitudes; bias 30 overflows the exponent and saturates
        vec   = '{16'h7BFF, 16'hFBFF, 16'h7800, 16'hF800, 16'h7000, 16'h5000, 16'h0000, 16'h7BFF};
        push_block("t3");
        exp_m = '{127, -127, 64, -64, 16, 0, 0, 127};
        chk_blk("t3", exp_a, man_a, 24);
        chk_blk("t3 b0", exp_b, man_b, 9);
        exp_m = '{127, -127, 127, -127, 127, 0, 0, 127};
        chk_blk("t3 b30 sat", exp_c, man_c, 31);
        release_block("t3");

        // zeros and denormals give an all-zero block
        vec   = '{16'h0001, 16'h8001, 16'h03FF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        push_block("t4");
        exp_m = '{0, 0, 0, 0, 0, 0, 0, 0};
        chk_blk("t4", exp_a, man_a, 0);
        chk_blk("t4 b30", exp_c, man_c, 0);
        release_block("t4");

        // stalled consumer with input pressure
        vec   = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
        push_block("t5");
        i_valid  = 1'b1;
        i_result = 16'h7BFF;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            chk($sformatf("t5 stall%0d o_ready", c), 32'(rdy_a), 0);
            chk($sformatf("t5 stall%0d o_valid", c), 32'(vld_a), 1);
            chk($sformatf("t5 stall%0d exp", c), 32'(exp_a), 9);
            chk($sformatf("t5 stall%0d m0", c), 32'($signed(man_a[0])), 64);
        end
        i_valid = 1'b0;
        release_block("t5");
        vec   = '{16'h3800, 16'h3C00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        push_block("t5 next");
        exp_m = '{32, 64, 0, 0, 0, 0, 0, 0};
        chk_blk("t5 next", exp_a, man_a, 9);
        release_block("t5 next");

        // reset discards a partial block
        for (int i = 0; i < 5; i++) push_one("t6 partial", 16'h7BFF);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("t6 rst o_valid", 32'(vld_a), 0);
        chk("t6 rst o_ready", 32'(rdy_a), 1);
        vec   = '{16'h3C00, 16'h3800, 16'hBC00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        push_block("t6");
        exp_m = '{64, 32, -64, 0, 0, 0, 0, 0};
        chk_blk("t6", exp_a, man_a, 9);
        release_block("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
